// File: rtl/univ_counter.sv
// n-bit universal counter: synchronous load, count up or count down every cycle.
// Priority is rst > ld > up/down, and z comes straight from the state register.
module univ_counter #(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [n-1:0] d_in,
  input  logic         ld,
  input  logic         up,
  output logic [n-1:0] z
);

  logic [n-1:0] z_q;
  logic [n-1:0] z_d;

  // Add and subtract are both n bits wide, so wrap-around needs no extra logic.
  always_comb begin
    z_d = z_q;
    if (ld)
      z_d = d_in;
    else if (up)
      z_d = z_q + {{(n-1){1'b0}}, 1'b1};
    else
      z_d = z_q - {{(n-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst)
      z_q <= '0;
    else
      z_q <= z_d;
  end

  assign z = z_q;

endmodule

// File: tb/tb_univ_counter.sv
// Bench for univ_counter (n=4): a directed sequence, then random stimulus.
// Both are checked against an integer reference model of the counter.
module tb_univ_counter;

  localparam int N   = 4;
  localparam int MOD = 1 << N;

  logic         clk;
  logic         rst;
  logic [N-1:0] d_in;
  logic         ld;
  logic         up;
  logic [N-1:0] z;

  int n_chk;
  int n_pass;
  int exp_z;

  univ_counter #(.n(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .d_in (d_in),
    .ld   (ld),
    .up   (up),
    .z    (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int want);
    n_chk++;
    if (got == want)
      n_pass++;
    else
      $display("FAIL %s: z=%0d expected %0d", tag, got, want);
  endtask

  // Drive one cycle of inputs, advance the model at the edge, then compare 1 ns later.
  task automatic step(input string tag, input logic r, input logic l,
                      input logic u, input int d);
    rst  = r;
    ld   = l;
    up   = u;
    d_in = N'(d);
    @(posedge clk);
    if (r)
      exp_z = 0;
    else if (l)
      exp_z = d % MOD;
    else if (u)
      exp_z = (exp_z + 1) % MOD;
    else
      exp_z = (exp_z + MOD - 1) % MOD;
    #1;
    chk(tag, int'(z), exp_z);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    exp_z  = 0;
    rst = 1'b1; ld = 1'b0; up = 1'b1; d_in = 4'd8;
    #2;

    // Reset, then count up from 0.
    step("reset0", 1, 0, 1, 8);
    step("reset1", 1, 0, 1, 8);
    chk("reset_val", int'(z), 0);
    for (int i = 0; i < 3; i++) step("count_up", 0, 0, 1, 8);
    chk("up_to_3", int'(z), 3);

    // Keep counting up through the 15 -> 0 wrap.
    for (int i = 0; i < 14; i++) step("up_wrap", 0, 0, 1, 8);
    chk("wrap_to_1", int'(z), 1);

    // Count down through the 0 -> 15 wrap until z = 5.
    step("down_a", 0, 0, 0, 8);
    chk("down_at_0", int'(z), 0);
    step("down_wrap", 0, 0, 0, 8);
    chk("down_wrap_15", int'(z), 15);
    for (int i = 0; i < 10; i++) step("down", 0, 0, 0, 8);
    chk("down_to_5", int'(z), 5);

    // Load takes priority over up; counting continues from the loaded value.
    step("load", 0, 1, 1, 8);
    chk("load_8", int'(z), 8);
    for (int i = 0; i < 21; i++) step("after_load", 0, 0, 1, 8);
    chk("after_load_13", int'(z), 13);

    // While ld is held, z holds d_in and follows a change of d_in one cycle later.
    for (int i = 0; i < 4; i++) step("held_load", 0, 1, 1, 8);
    chk("held_8", int'(z), 8);
    step("load_3", 0, 1, 1, 3);
    chk("load_3_val", int'(z), 3);

    // Reset overrides ld, and counting restarts from 0 once it is released.
    step("rst_over_ld", 1, 1, 1, 9);
    chk("rst_mid", int'(z), 0);
    step("restart", 0, 0, 1, 9);
    chk("restart_1", int'(z), 1);
    // Changing direction takes effect on the very next edge.
    step("dir_chg", 0, 0, 0, 9);
    chk("dir_chg_0", int'(z), 0);

    // Random stimulus: rst and ld kept rare so that long count runs occur.
    for (int i = 0; i < 400; i++) begin
      step("rand",
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 7) == 0,
           1'($urandom),
           int'($urandom_range(0, MOD - 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
